// File: rtl/hazard_sequencer_if.sv
// rtl/hazard_sequencer_if.sv - ID-stage decode inputs and hazard control outputs
interface hazard_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ID_Rs;
    logic [4:0]       ID_Rt;
    logic             ID_UsesRs;
    logic             ID_UsesRt;
    logic [4:0]       ID_Dest;
    logic             ID_RegWrite;
    logic             ID_Load;
    logic             ID_IsMul;
    logic             ID_Jump;
    logic             EX_BranchTaken;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             IFIDFlush;
    logic             IDEXBubble;
    logic [1:0]       ForwardA;
    logic [1:0]       ForwardB;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_Dest, ID_RegWrite,
               ID_Load, ID_IsMul, ID_Jump, EX_BranchTaken,
        input  PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, ForwardA, ForwardB,
               StallCount
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_Dest, ID_RegWrite,
               ID_Load, ID_IsMul, ID_Jump, EX_BranchTaken,
        output PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, ForwardA, ForwardB,
               StallCount
    );
endinterface

// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - ID-stage hazard scoreboard, stall/flush control and forward selects
module hazard_sequencer #(
    parameter int MUL_CYCLES = 3,
    parameter int CNT_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    hazard_sequencer_if.slave hz
);
    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MUL_WAIT = 1'b1;

    typedef struct packed {
        logic       v;
        logic [4:0] dst;
        logic       ld;
    } slot_t;

    slot_t            ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [0:0]       state_q, state_d;
    logic [3:0]       mcnt_q, mcnt_d;
    logic [1:0]       fwda_q, fwda_d, fwdb_q, fwdb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic load_use, in_mul, stall, issue, branch;

    function automatic logic match(input logic use_src, input logic [4:0] src, input slot_t s);
        return use_src && (src != 5'd0) && s.v && (s.dst == src);
    endfunction

    // A load still in ex never forwards from here: that case is a load-use stall instead.
    function automatic logic [1:0] fwd_sel(input logic use_src, input logic [4:0] src,
                                           input slot_t ex_s, input slot_t mem_s);
        if (match(use_src, src, ex_s) && !ex_s.ld)
            return 2'b01;
        else if (match(use_src, src, mem_s))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        branch   = hz.EX_BranchTaken;
        load_use = ex_q.ld && (match(hz.ID_UsesRs, hz.ID_Rs, ex_q) ||
                               match(hz.ID_UsesRt, hz.ID_Rt, ex_q));
        in_mul   = (state_q == ST_MUL_WAIT);
        stall    = (load_use || in_mul) && !branch;
        issue    = !stall && !branch;

        hz.PCWrite    = !stall;
        hz.IFIDWrite  = !stall;
        hz.IFIDFlush  = branch || (hz.ID_Jump && !stall);
        hz.IDEXBubble = stall || branch;
        hz.ForwardA   = fwda_q;
        hz.ForwardB   = fwdb_q;
        hz.StallCount = cnt_q;
    end

    always_comb begin
        state_d = state_q;
        mcnt_d  = mcnt_q;
        ex_d    = '0;
        mem_d   = ex_q;
        wb_d    = mem_q;
        fwda_d  = 2'b00;
        fwdb_d  = 2'b00;
        cnt_d   = cnt_q;

        if (branch) begin
            state_d = ST_RUN;
            mcnt_d  = 4'd0;
        end else if (in_mul) begin
            // The mul keeps occupying ex; nothing new enters mem behind it.
            ex_d  = ex_q;
            mem_d = '0;
            if (mcnt_q == 4'd0)
                state_d = ST_RUN;
            else
                mcnt_d = mcnt_q - 4'd1;
        end else if (issue) begin
            ex_d.v   = hz.ID_RegWrite && (hz.ID_Dest != 5'd0);
            ex_d.dst = hz.ID_Dest;
            ex_d.ld  = hz.ID_Load;
            fwda_d   = fwd_sel(hz.ID_UsesRs, hz.ID_Rs, ex_q, mem_q);
            fwdb_d   = fwd_sel(hz.ID_UsesRt, hz.ID_Rt, ex_q, mem_q);
            if (hz.ID_IsMul && (MUL_CYCLES > 1)) begin
                state_d = ST_MUL_WAIT;
                mcnt_d  = 4'(MUL_CYCLES - 2);
            end
        end

        if (stall && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            state_q <= ST_RUN;
            mcnt_q  <= 4'd0;
            fwda_q  <= 2'b00;
            fwdb_q  <= 2'b00;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
            fwda_q  <= fwda_d;
            fwdb_q  <= fwdb_d;
            cnt_q   <= cnt_d;
        end
    end

    // wb is tracked for completeness; write-first regfile covers it, so it feeds nothing.
    logic wb_unused;
    assign wb_unused = ^wb_q;
endmodule

// File: tb/tb_hazard_sequencer.sv
// tb/tb_hazard_sequencer.sv - randomized scoreboard bench for hazard_sequencer
module tb_hazard_sequencer;
    localparam int MUL_CYCLES = 3;
    localparam int CNT_W      = 6;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    hazard_sequencer_if #(.CNT_W(CNT_W)) hz ();

    hazard_sequencer #(.MUL_CYCLES(MUL_CYCLES), .CNT_W(CNT_W)) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .hz   (hz)
    );

    typedef struct {
        int rs, rt, dst;
        bit urs, urt, rw, ld, mul, jmp;
    } instr_t;

    typedef struct {
        int ctrl;
        int fa, fb, cnt;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   failures = 0;

    // Reference pipeline: index 0 = ex, 1 = mem, 2 = wb.
    bit m_v[3];
    int m_dst[3];
    bit m_ld[3];
    int mul_left, fa_r, fb_r, cnt;

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_v[i] = 0; m_dst[i] = 0; m_ld[i] = 0;
        end
        mul_left = 0; fa_r = 0; fb_r = 0; cnt = 0;
    endfunction

    function automatic int youngest(bit use_src, int src);
        if (!use_src || src == 0) return -1;
        for (int i = 0; i < 2; i++)
            if (m_v[i] && m_dst[i] == src) return i;
        return -1;
    endfunction

    function automatic int fwd_code(int age);
        return (age == 0) ? 1 : (age == 1) ? 2 : 0;
    endfunction

    function automatic void shift(bit nv, int nd, bit nl);
        m_v[2] = m_v[1]; m_dst[2] = m_dst[1]; m_ld[2] = m_ld[1];
        m_v[1] = m_v[0]; m_dst[1] = m_dst[0]; m_ld[1] = m_ld[0];
        m_v[0] = nv;     m_dst[0] = nd;       m_ld[0] = nl;
    endfunction

    function automatic instr_t mk(int rs, int rt, bit urs, bit urt, int dst,
                                  bit rw, bit ld, bit mul, bit jmp);
        instr_t r;
        r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt; r.dst = dst;
        r.rw = rw; r.ld = ld; r.mul = mul; r.jmp = jmp;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input instr_t in, input bit br, input bit rst, output bit issued);
        exp_t e;
        int   ya, yb;
        bit   lu, st;
        @(posedge Clk);
        #1;
        hz.ID_Rs = 5'(in.rs); hz.ID_Rt = 5'(in.rt);
        hz.ID_UsesRs = in.urs; hz.ID_UsesRt = in.urt;
        hz.ID_Dest = 5'(in.dst); hz.ID_RegWrite = in.rw;
        hz.ID_Load = in.ld; hz.ID_IsMul = in.mul; hz.ID_Jump = in.jmp;
        hz.EX_BranchTaken = br;
        Reset = rst;

        ya = youngest(in.urs, in.rs);
        yb = youngest(in.urt, in.rt);
        lu = m_ld[0] && (ya == 0 || yb == 0);
        st = (lu || mul_left > 0) && !br;
        e.ctrl = {!st, !st, br || (in.jmp && !st), st || br};
        e.fa = fa_r; e.fb = fb_r; e.cnt = cnt;
        expq.push_back(e);
        issued = !st && !br && !rst;

        if (rst) begin
            model_reset();
        end else begin
            if (st && cnt < CNT_MAX) cnt++;
            fa_r = issued ? fwd_code(ya) : 0;
            fb_r = issued ? fwd_code(yb) : 0;
            if (br) begin
                shift(0, 0, 0);
                mul_left = 0;
            end else if (mul_left > 0) begin
                m_v[2] = m_v[1]; m_dst[2] = m_dst[1]; m_ld[2] = m_ld[1];
                m_v[1] = 0; m_dst[1] = 0; m_ld[1] = 0;
                mul_left--;
            end else if (lu) begin
                shift(0, 0, 0);
            end else begin
                shift(in.rw && in.dst != 0, in.dst, in.ld);
                if (in.mul) mul_left = MUL_CYCLES - 1;
            end
        end
    endtask

    task automatic run(input instr_t in);
        bit iss;
        for (int k = 0; k < 20; k++) begin
            step(in, 0, 0, iss);
            if (iss) return;
        end
        chk("issue_timeout", 0, 1);
    endtask

    always @(negedge Clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("ctrl{pcw,ifidw,flush,bubble}",
                int'({hz.PCWrite, hz.IFIDWrite, hz.IFIDFlush, hz.IDEXBubble}), e.ctrl);
            chk("ForwardA", int'(hz.ForwardA), e.fa);
            chk("ForwardB", int'(hz.ForwardB), e.fb);
            chk("StallCount", int'(hz.StallCount), e.cnt);
        end
    end

    initial begin
        instr_t nop, add3, sub4, lw8, add10, mul2, addi0, add2, jmp, jal, cur;
        bit     iss, have, br, rst;

        nop   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add3  = mk(1, 2, 1, 1, 3, 1, 0, 0, 0);
        sub4  = mk(3, 5, 1, 1, 4, 1, 0, 0, 0);
        lw8   = mk(9, 0, 1, 0, 8, 1, 1, 0, 0);
        add10 = mk(8, 8, 1, 1, 10, 1, 0, 0, 0);
        mul2  = mk(3, 4, 1, 1, 2, 1, 0, 1, 0);
        addi0 = mk(1, 0, 1, 0, 0, 1, 0, 0, 0);
        add2  = mk(0, 0, 1, 1, 2, 1, 0, 0, 0);
        jmp   = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
        jal   = mk(0, 0, 0, 0, 31, 1, 0, 0, 1);

        Reset = 1'b1;
        hz.ID_Rs = '0; hz.ID_Rt = '0; hz.ID_UsesRs = 0; hz.ID_UsesRt = 0;
        hz.ID_Dest = '0; hz.ID_RegWrite = 0; hz.ID_Load = 0; hz.ID_IsMul = 0;
        hz.ID_Jump = 0; hz.EX_BranchTaken = 0;
        repeat (2) @(posedge Clk);
        model_reset();

        run(nop);
        run(add3); run(sub4); run(nop); run(nop);
        run(add3); run(nop); run(sub4); run(nop); run(nop);
        run(add3); run(nop); run(nop); run(sub4); run(nop); run(nop);
        run(lw8); run(add10); run(nop); run(nop);
        run(mul2); run(nop); run(nop); run(nop);
        run(lw8); step(add10, 1, 0, iss); run(nop); run(nop);
        run(addi0); run(add2); run(nop); run(jmp); run(nop); run(jal); run(add10); run(nop);
        run(mul2); step(nop, 0, 1, iss); run(nop); run(nop);

        have = 0;
        for (int n = 0; n < 800; n++) begin
            if (!have) begin
                cur.rs  = $urandom_range(0, 7); cur.rt = $urandom_range(0, 7);
                cur.urs = ($urandom_range(0, 9) < 8); cur.urt = ($urandom_range(0, 9) < 6);
                cur.dst = $urandom_range(0, 7); cur.rw = ($urandom_range(0, 9) < 8);
                cur.ld  = ($urandom_range(0, 9) < 3);
                cur.mul = !cur.ld && ($urandom_range(0, 9) < 1);
                cur.jmp = !cur.ld && !cur.mul && ($urandom_range(0, 9) < 1);
                have = 1;
            end
            br  = ($urandom_range(0, 99) < 8);
            rst = ($urandom_range(0, 199) < 1);
            step(cur, br, rst, iss);
            if (iss || br || rst) have = 0;
        end

        for (int n = 0; n < 40; n++) begin
            run(mul2); run(nop);
        end
        run(lw8); run(add10); run(nop);

        repeat (2) @(negedge Clk);
        chk("scoreboard_drained", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
